// File: rtl/multipush_multiport_fifo.sv
// Multi-producer / multi-consumer FIFO: up to NrWritePort in-order pushes per cycle,
// NrReadPort independent readers; an entry is freed once the slowest reader has consumed it.
module multipush_multiport_fifo #(
    parameter int unsigned NrReadPort  = 2,
    parameter int unsigned NrWritePort = 2,
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned Depth       = 8,
    parameter type         dtype       = logic [DataWidth-1:0],
    parameter int unsigned AddrDepth   = (Depth > 1) ? $clog2(Depth) : 1,
    parameter type         cnt_t       = logic [AddrDepth:0],
    parameter type         wcnt_t      = logic [$clog2(NrWritePort+1)-1:0]
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  push_valid_i,
    input  wcnt_t                 push_cnt_i,
    input  dtype                  data_i [NrWritePort],
    output logic                  push_ready_o,
    output cnt_t                  free_o,
    output logic                  full_o,
    output dtype                  data_o [NrReadPort],
    output logic [NrReadPort-1:0] empty_o,
    output cnt_t                  usage_o [NrReadPort],
    input  logic [NrReadPort-1:0] pop_i
);

    typedef logic [AddrDepth-1:0] ptr_t;
    localparam cnt_t DepthCnt = cnt_t'(Depth);

    dtype mem_q  [Depth];
    dtype mem_d  [Depth];
    ptr_t wptr_q, wptr_d;
    ptr_t rptr_q [NrReadPort];
    ptr_t rptr_d [NrReadPort];
    cnt_t cnt_q  [NrReadPort];
    cnt_t cnt_d  [NrReadPort];
    cnt_t max_cnt;
    cnt_t push_cnt;
    logic push_fire;

    // Pointers stay below Depth and increments never exceed Depth, so a single
    // conditional subtract wraps correctly for non-power-of-two depths too.
    function automatic ptr_t wrap_add(ptr_t ptr, cnt_t inc);
        cnt_t sum;
        sum = cnt_t'(ptr) + inc;
        if (sum >= DepthCnt) sum = sum - DepthCnt;
        return ptr_t'(sum);
    endfunction

    always_comb begin
        max_cnt = '0;
        for (int unsigned r = 0; r < NrReadPort; r++) begin
            if (cnt_q[r] > max_cnt) max_cnt = cnt_q[r];
        end
    end

    assign push_cnt     = cnt_t'(push_cnt_i);
    assign free_o       = DepthCnt - max_cnt;
    assign full_o       = (free_o == '0);
    // Built from registered counts only: space freed by a same-cycle pop waits a cycle.
    assign push_ready_o = (push_cnt <= free_o);
    assign push_fire    = push_valid_i && push_ready_o && (push_cnt_i != '0);

    // NOTE: every always_comb output gets its default first so no path can infer a latch.
    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (flush_i) begin
            wptr_d = '0;
            for (int unsigned r = 0; r < NrReadPort; r++) begin
                rptr_d[r] = '0;
                cnt_d[r]  = '0;
            end
        end else begin
            if (push_fire) begin
                for (int unsigned k = 0; k < NrWritePort; k++) begin
                    if (cnt_t'(k) < push_cnt) mem_d[wrap_add(wptr_q, cnt_t'(k))] = data_i[k];
                end
                wptr_d = wrap_add(wptr_q, push_cnt);
            end
            for (int unsigned r = 0; r < NrReadPort; r++) begin
                cnt_d[r] = cnt_q[r] + (push_fire ? push_cnt : '0);
                if (pop_i[r] && (cnt_q[r] != '0)) begin
                    rptr_d[r] = wrap_add(rptr_q[r], cnt_t'(1));
                    cnt_d[r]  = cnt_d[r] - cnt_t'(1);
                end
            end
        end
    end

    // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            for (int unsigned r = 0; r < NrReadPort; r++) begin
                rptr_q[r] <= '0;
                cnt_q[r]  <= '0;
            end
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // NOTE: the storage array has no reset; stale slots are masked by empty_o.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    always_comb begin
        empty_o = '0;
        for (int unsigned r = 0; r < NrReadPort; r++) begin
            data_o[r]  = mem_q[rptr_q[r]];
            usage_o[r] = cnt_q[r];
            empty_o[r] = (cnt_q[r] == '0);
        end
    end

    push_cnt_legal_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        push_valid_i |-> (push_cnt <= cnt_t'(NrWritePort)));

endmodule

// File: tb/tb_multipush_multiport_fifo.sv
// Self-checking bench: a Depth=8 and a Depth=6 FIFO share stimulus and are compared each
// cycle against a stream/consumed-index reference model, plus directed scenario checks.
module tb_multipush_multiport_fifo;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        flush_i;
    logic        push_valid_i;
    logic [1:0]  push_cnt_i;
    logic [31:0] din [2];
    logic [1:0]  pop_i;

    logic        ready8, full8, ready6, full6;
    logic [3:0]  free8, free6;
    logic [31:0] data8 [2];
    logic [31:0] data6 [2];
    logic [1:0]  empty8, empty6;
    logic [3:0]  use8 [2];
    logic [3:0]  use6 [2];

    always #5 clk_i = ~clk_i;

    multipush_multiport_fifo #(.NrReadPort(2), .NrWritePort(2), .DataWidth(32), .Depth(8)) u_dut8 (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .push_valid_i(push_valid_i),
        .push_cnt_i(push_cnt_i), .data_i(din), .push_ready_o(ready8), .free_o(free8),
        .full_o(full8), .data_o(data8), .empty_o(empty8), .usage_o(use8), .pop_i(pop_i)
    );

    multipush_multiport_fifo #(.NrReadPort(2), .NrWritePort(2), .DataWidth(32), .Depth(6)) u_dut6 (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .push_valid_i(push_valid_i),
        .push_cnt_i(push_cnt_i), .data_i(din), .push_ready_o(ready6), .free_o(free6),
        .full_o(full6), .data_o(data6), .empty_o(empty6), .usage_o(use6), .pop_i(pop_i)
    );

    // Reference model: every accepted element gets an absolute stream index; each reader
    // holds the absolute index of its next unread element.
    int unsigned wr [2];
    int unsigned rd [2][2];
    logic [31:0] strm [2][4096];
    logic        acc [2];
    logic        pf [2][2];
    logic [31:0] seen6 [2];
    logic [31:0] abc [3];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int depth_of(input int m);
        return (m == 0) ? 8 : 6;
    endfunction

    function automatic int occ(input int m);
        int mx = 0;
        for (int r = 0; r < 2; r++) begin
            if (int'(wr[m] - rd[m][r]) > mx) mx = int'(wr[m] - rd[m][r]);
        end
        return mx;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            wr[m] = 0;
            for (int r = 0; r < 2; r++) rd[m][r] = 0;
        end
    endtask

    task automatic model_check();
        logic [3:0]  o_free [2];
        logic        o_full [2];
        logic        o_rdy [2];
        logic [1:0]  o_empty [2];
        logic [3:0]  o_use [2][2];
        logic [31:0] o_data [2][2];
        o_free[0] = free8;   o_free[1] = free6;
        o_full[0] = full8;   o_full[1] = full6;
        o_rdy[0] = ready8;   o_rdy[1] = ready6;
        o_empty[0] = empty8; o_empty[1] = empty6;
        for (int r = 0; r < 2; r++) begin
            o_use[0][r] = use8[r];   o_use[1][r] = use6[r];
            o_data[0][r] = data8[r]; o_data[1][r] = data6[r];
        end
        for (int m = 0; m < 2; m++) begin
            int fr;
            fr = depth_of(m) - occ(m);
            check($sformatf("d%0d free", depth_of(m)), 32'(o_free[m]), 32'(fr));
            check($sformatf("d%0d full", depth_of(m)), 32'(o_full[m]), 32'(fr == 0));
            check($sformatf("d%0d ready", depth_of(m)), 32'(o_rdy[m]), 32'(int'(push_cnt_i) <= fr));
            for (int r = 0; r < 2; r++) begin
                int u;
                u = int'(wr[m] - rd[m][r]);
                check($sformatf("d%0d usage[%0d]", depth_of(m), r), 32'(o_use[m][r]), 32'(u));
                check($sformatf("d%0d empty[%0d]", depth_of(m), r), 32'(o_empty[m][r]), 32'(u == 0));
                if (u > 0)
                    check($sformatf("d%0d data[%0d]", depth_of(m), r), o_data[m][r],
                          strm[m][rd[m][r] % 4096]);
            end
        end
    endtask

    task automatic model_update();
        for (int m = 0; m < 2; m++) begin
            int fr;
            fr = depth_of(m) - occ(m);
            acc[m] = push_valid_i && (push_cnt_i != 0) && (int'(push_cnt_i) <= fr);
            for (int r = 0; r < 2; r++) pf[m][r] = pop_i[r] && (wr[m] != rd[m][r]);
            if (flush_i) begin
                acc[m] = 1'b0;
                for (int r = 0; r < 2; r++) begin
                    pf[m][r] = 1'b0;
                    rd[m][r] = wr[m];
                end
            end else begin
                if (acc[m]) begin
                    for (int k = 0; k < int'(push_cnt_i); k++) strm[m][(wr[m] + k) % 4096] = din[k];
                    wr[m] += push_cnt_i;
                end
                for (int r = 0; r < 2; r++) if (pf[m][r]) rd[m][r]++;
            end
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] c, input logic [31:0] d0,
                         input logic [31:0] d1, input logic [1:0] p, input logic f);
        push_valid_i = v;
        push_cnt_i   = c;
        din[0]       = d0;
        din[1]       = d1;
        pop_i        = p;
        flush_i      = f;
    endtask

    // Called at a falling edge: check outputs, advance the model, move to the next falling edge.
    task automatic step();
        #1;
        model_check();
        seen6[0] = data6[0];
        seen6[1] = data6[1];
        model_update();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int push_idx;
        int exp_n [2];
        bit done;

        abc[0] = 32'h0000_000A;
        abc[1] = 32'h0000_000B;
        abc[2] = 32'h0000_000C;
        rst_ni = 1'b0;
        drive(1'b0, 2'd2, 32'h0, 32'h0, 2'b00, 1'b0);
        model_reset();
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;

        // Reset / empty
        #1;
        check("reset free8", 32'(free8), 32'd8);
        check("reset free6", 32'(free6), 32'd6);
        check("reset empty8", 32'(empty8), 32'h3);
        check("reset full8", 32'(full8), 32'd0);
        check("reset ready8 cnt2", 32'(ready8), 32'd1);
        drive(1'b0, 2'd0, 32'h0, 32'h0, 2'b11, 1'b0);
        step();
        check("pop-empty usage8[0]", 32'(use8[0]), 32'd0);
        check("pop-empty empty8", 32'(empty8), 32'h3);

        // Multi-push order
        drive(1'b1, 2'd2, abc[0], abc[1], 2'b00, 1'b0);
        step();
        drive(1'b1, 2'd1, abc[2], 32'h0, 2'b00, 1'b0);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 2'd0, 32'h0, 32'h0, 2'b01, 1'b0);
            #1;
            check($sformatf("order data8[0] #%0d", i), data8[0], abc[i]);
            check($sformatf("order usage8[1] #%0d", i), 32'(use8[1]), 32'd3);
            step();
        end
        #1;
        check("order empty8[0]", 32'(empty8[0]), 32'd1);
        check("order usage8[1] end", 32'(use8[1]), 32'd3);

        // Slow reader holds space
        drive(1'b0, 2'd0, 32'h0, 32'h0, 2'b00, 1'b1);
        step();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'd2, 32'(100 + 2 * i), 32'(101 + 2 * i), 2'b00, 1'b0);
            step();
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 2'd0, 32'h0, 32'h0, 2'b01, 1'b0);
            step();
        end
        drive(1'b1, 2'd1, 32'h0000_0BAD, 32'h0, 2'b00, 1'b0);
        #1;
        check("slow free8", 32'(free8), 32'd0);
        check("slow full8", 32'(full8), 32'd1);
        check("slow ready8 cnt1", 32'(ready8), 32'd0);
        step();
        check("slow rejected usage8[1]", 32'(use8[1]), 32'd8);
        drive(1'b0, 2'd0, 32'h0, 32'h0, 2'b10, 1'b0);
        step();
        check("slow free8 after pop", 32'(free8), 32'd1);

        // All-or-nothing
        drive(1'b1, 2'd2, 32'hAAAA_0001, 32'hAAAA_0002, 2'b00, 1'b0);
        #1;
        check("aon ready8 cnt2", 32'(ready8), 32'd0);
        step();
        check("aon usage8[1] unchanged", 32'(use8[1]), 32'd7);
        check("aon usage8[0] unchanged", 32'(use8[0]), 32'd0);
        drive(1'b1, 2'd1, 32'hAAAA_0001, 32'h0, 2'b00, 1'b0);
        #1;
        check("aon ready8 cnt1", 32'(ready8), 32'd1);
        step();
        check("aon usage8[1] accepted", 32'(use8[1]), 32'd8);
        check("aon head8[0] is X", data8[0], 32'hAAAA_0001);
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 2'd0, 32'h0, 32'h0, 2'b11, 1'b0);
            step();
        end
        check("aon Y never stored", 32'(empty8), 32'h3);

        // Flush with simultaneous push and pops
        drive(1'b1, 2'd2, 32'h55, 32'h66, 2'b00, 1'b0);
        step();
        drive(1'b1, 2'd2, 32'h77, 32'h88, 2'b11, 1'b1);
        step();
        check("flush usage8[0]", 32'(use8[0]), 32'd0);
        check("flush usage6[1]", 32'(use6[1]), 32'd0);
        check("flush free6", 32'(free6), 32'd6);
        check("flush free8", 32'(free8), 32'd8);
        check("flush empty6", 32'(empty6), 32'h3);

        // Wrap on Depth=6: 20 pushes of two incrementing elements under random pop stalls
        push_idx = 0;
        exp_n[0] = 0;
        exp_n[1] = 0;
        done = 1'b0;
        for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
            drive(push_idx < 20, 2'd2, 32'(2 * push_idx), 32'(2 * push_idx + 1),
                  {$urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0}, 1'b0);
            step();
            if (acc[1]) push_idx++;
            for (int r = 0; r < 2; r++) begin
                if (pf[1][r]) begin
                    check($sformatf("wrap6 order r%0d", r), seen6[r], 32'(exp_n[r]));
                    exp_n[r]++;
                end
            end
            done = (push_idx == 20) && (exp_n[0] == 40) && (exp_n[1] == 40);
        end
        check("wrap6 reader0 count", 32'(exp_n[0]), 32'd40);
        check("wrap6 reader1 count", 32'(exp_n[1]), 32'd40);

        // Randomized traffic
        for (int cyc = 0; cyc < 400; cyc++) begin
            drive($urandom_range(0, 1) == 1, 2'($urandom_range(0, 2)), $urandom, $urandom,
                  2'($urandom_range(0, 3)), $urandom_range(0, 39) == 0);
            step();
        end

        // Asynchronous reset mid-stream
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'd2, $urandom, $urandom, 2'b00, 1'b0);
            step();
        end
        drive(1'b1, 2'd2, 32'h1234, 32'h5678, 2'b11, 1'b0);
        #2;
        rst_ni = 1'b0;
        #1;
        check("async rst free8", 32'(free8), 32'd8);
        check("async rst free6", 32'(free6), 32'd6);
        check("async rst empty8", 32'(empty8), 32'h3);
        check("async rst empty6", 32'(empty6), 32'h3);
        check("async rst usage6[0]", 32'(use6[0]), 32'd0);
        model_reset();
        @(negedge clk_i);
        drive(1'b0, 2'd0, 32'h0, 32'h0, 2'b00, 1'b0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            drive($urandom_range(0, 1) == 1, 2'($urandom_range(0, 2)), $urandom, $urandom,
                  2'($urandom_range(0, 3)), 1'b0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
